// File: rtl/empaquetador_simbolos.sv
// Symbol packer: gathers SYMBOLS narrow symbols LSB-first into one word
// and queues completed words in a first-word-fall-through FIFO.
module empaquetador_simbolos #(
  parameter int SYM_W   = 2,
  parameter int SYMBOLS = 4,
  parameter int DEPTH   = 4,
  localparam int W  = SYM_W * SYMBOLS,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(SYMBOLS),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [SYM_W-1:0] data_in,
  input  logic          valid_in,
  output logic          in_ready,
  output logic [W-1:0]  data_out,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [CW-1:0] count,
  output logic [SW-1:0] sym_cnt,
  output logic          overflow
);

  logic [W-1:0]  sr_q;
  logic [W-1:0]  word_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          run_q;
  logic          accept;
  logic          last;
  logic          push;
  logic          pop;
  logic [W-1:0]  mem [DEPTH];

  // run_q keeps in_ready low until the first edge after reset release
  assign in_ready  = run_q && (count != CW'(DEPTH));
  assign valid_out = (count != '0);
  assign data_out  = valid_out ? mem[rd_ptr] : '0;

  assign accept   = valid_in && in_ready;
  assign last     = (sym_cnt == SW'(SYMBOLS - 1));
  assign word_nxt = sr_q | (W'(data_in) << (SYM_W * int'(sym_cnt)));
  assign push     = accept && last;
  assign pop      = valid_out && ready_out;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      run_q    <= 1'b0;
      sym_cnt  <= '0;
      sr_q     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        sym_cnt <= last ? '0 : sym_cnt + SW'(1);
        sr_q    <= last ? '0 : word_nxt;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (valid_in && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_nxt;
  end

endmodule

// File: tb/tb_empaquetador_simbolos.sv
// Bench for empaquetador_simbolos: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_empaquetador_simbolos;

  localparam int DEPTH = 4;
  localparam int SYMBOLS = 4;

  logic       clk;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       in_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_out;
  logic [2:0] count;
  logic [1:0] sym_cnt;
  logic       overflow;

  empaquetador_simbolos dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .count     (count),
    .sym_cnt   (sym_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [$];
  logic [1:0] syms [$];
  logic [7:0] popped [$];
  logic       m_run;
  logic       m_ovf;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    return m_run && (q.size() != DEPTH);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(q.size() != 0));
    check({tag, ".data_out"}, 32'(data_out),
          (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".sym_cnt"}, 32'(sym_cnt), 32'(syms.size()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Called at a negedge: drive, advance one clock, compare at next negedge.
  task automatic step(input string tag, input logic v,
                      input logic [1:0] d, input logic r);
    logic acc, pp, drop;
    logic [7:0] w;
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    acc  = v && m_ready();
    drop = v && !m_ready();
    pp   = (q.size() != 0) && r;
    if (pp) popped.push_back(data_out);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      syms.push_back(d);
      if (syms.size() == SYMBOLS) begin
        w = '0;
        foreach (syms[k]) w = w | (8'(syms[k]) << (2 * k));
        q.push_back(w);
        syms.delete();
      end
    end
    if (drop) m_ovf = 1'b1;
    m_run = 1'b1;
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_L = 1'b0;
    #1;
    q.delete();
    syms.delete();
    m_run = 1'b0;
    m_ovf = 1'b0;
    compare_all(tag);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    logic r;
    reset_L   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 2'b00;
    ready_out = 1'b0;
    m_run     = 1'b0;
    m_ovf     = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("rst");
    reset_L = 1'b1;
    step("idle", 1'b0, 2'b00, 1'b0);

    // T1 basic
    step("t1", 1'b1, 2'b01, 1'b1);
    step("t1", 1'b1, 2'b10, 1'b1);
    step("t1", 1'b1, 2'b11, 1'b1);
    step("t1", 1'b1, 2'b00, 1'b1);
    check("t1.word", 32'(data_out), 32'h39);
    step("t1pop", 1'b0, 2'b00, 1'b1);
    check("t1.empty", 32'(valid_out), 32'd0);

    // T2 fill to full, then overflow
    for (int i = 0; i < 16; i++) step("t2", 1'b1, 2'b11, 1'b0);
    check("t2.count", 32'(count), 32'd4);
    check("t2.word", 32'(data_out), 32'hFF);
    step("t2ovf", 1'b1, 2'b11, 1'b0);
    check("t2.ovf", 32'(overflow), 32'd1);

    // T3 pop at full while offering a symbol
    step("t3", 1'b1, 2'b01, 1'b1);
    check("t3.count", 32'(count), 32'd3);
    check("t3.sym", 32'(sym_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step("t3drain", 1'b0, 2'b00, 1'b1);

    // T4 gaps inside a word
    step("t4", 1'b1, 2'b11, 1'b0);
    step("t4", 1'b0, 2'b10, 1'b0);
    step("t4", 1'b0, 2'b01, 1'b0);
    step("t4", 1'b1, 2'b01, 1'b0);
    step("t4", 1'b0, 2'b11, 1'b0);
    step("t4", 1'b1, 2'b10, 1'b0);
    step("t4", 1'b1, 2'b00, 1'b0);
    check("t4.count", 32'(count), 32'd1);
    step("t4drain", 1'b0, 2'b00, 1'b1);

    // T5 reset mid-operation
    for (int i = 0; i < 10; i++)
      step("t5", 1'b1, 2'(i), 1'b0);
    do_reset("t5rst");
    step("t5idle", 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step("t5", 1'b1, 2'(i), 1'b0);
    check("t5.word", 32'(data_out), 32'hE4);
    step("t5drain", 1'b0, 2'b00, 1'b1);

    // T6 ordering with toggling downstream ready
    popped.delete();
    r = 1'b1;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) begin
        step("t6", 1'b1, 2'((n >> (2 * k)) & 3), r);
        r = ~r;
      end
    end
    for (int i = 0; i < 8; i++) step("t6drain", 1'b0, 2'b00, 1'b1);
    check("t6.n", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check("t6.order", 32'(popped[i]), 32'(i));
    check("t6.ovf", 32'(overflow), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_rst");
        step("rnd", 1'b0, 2'b00, 1'b0);
      end else begin
        step("rnd", 1'($urandom_range(0, 3) != 0),
             2'($urandom), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
